// File: rtl/rs_pkg.sv
// Shared RS(15,11) definitions over GF(16): field/code sizes, generator taps,
// controller states and a generic GF(16) multiply.
package rs_pkg;
   localparam int SYM_W = 4;
   localparam int N     = 15;
   localparam int K     = 11;
   localparam int NPAR  = N - K;

   localparam logic [3:0] GF_PRIM = 4'b0011;
   localparam logic [3:0] G3 = 4'hD;
   localparam logic [3:0] G2 = 4'hC;
   localparam logic [3:0] G1 = 4'h8;
   localparam logic [3:0] G0 = 4'h7;

   typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

   typedef struct packed {
      logic [SYM_W-1:0] dat;
      logic             vld;
      logic             first;
      logic             last;
   } out_t;

   // Shift-and-add multiply; reduces by x^4 = x + 1 on each carry out.
   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) p = p ^ t;
         t = t[3] ? ({t[2:0], 1'b0} ^ GF_PRIM) : {t[2:0], 1'b0};
      end
      return p;
   endfunction
endpackage

// File: rtl/rs15_11_encoder_if.sv
// Symbol stream into the encoder and codeword stream out of it.
interface rs15_11_encoder_if;
   import rs_pkg::*;
   logic [SYM_W-1:0] DATA_IN;
   logic             IN_VALID;
   logic             IN_READY;
   logic [SYM_W-1:0] DATA_OUT;
   logic             OUT_VALID;
   logic             OUT_FIRST;
   logic             OUT_LAST;

   modport master (output DATA_IN, IN_VALID,
                   input  IN_READY, DATA_OUT, OUT_VALID, OUT_FIRST, OUT_LAST);
   modport slave  (input  DATA_IN, IN_VALID,
                   output IN_READY, DATA_OUT, OUT_VALID, OUT_FIRST, OUT_LAST);
endinterface

// File: rtl/gf16_const_mul.sv
// Combinational multiply by a constant in GF(16); collapses to an XOR network.
module gf16_const_mul
   import rs_pkg::*;
#(
   parameter logic [3:0] COEFF = 4'h1
) (
   input  logic [3:0] i_a,
   output logic [3:0] o_p
);
   assign o_p = gf_mul(i_a, COEFF);
endmodule

// File: rtl/rs15_11_encoder.sv
// Streaming systematic RS(15,11) encoder: echoes 11 message symbols, then
// emits 4 parity symbols from a generator-polynomial LFSR.
module rs15_11_encoder
   import rs_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET_N,
   rs15_11_encoder_if.slave    bus
);
   localparam logic [NPAR-1:0][SYM_W-1:0] GCOEF = {G3, G2, G1, G0};

   state_t                      r_state, w_state_nxt;
   logic [3:0]                  r_cnt, w_cnt_nxt;
   logic [NPAR-1:0][SYM_W-1:0]  r_lfsr;
   logic [NPAR-1:0][SYM_W-1:0]  w_tap;
   logic [SYM_W-1:0]            w_fb;
   logic                        r_rdy, w_rdy_nxt;
   logic                        w_acc;
   out_t                        r_out, w_out_nxt;

   assign w_acc = bus.IN_VALID && r_rdy;
   assign w_fb  = bus.DATA_IN ^ r_lfsr[NPAR-1];

   for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
      gf16_const_mul #(.COEFF(GCOEF[gi])) u_mul (
         .i_a (w_fb),
         .o_p (w_tap[gi])
      );
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: if (w_acc) begin
            w_state_nxt = MSG;
            w_cnt_nxt   = 4'd1;
         end
         MSG: if (w_acc) begin
            if (r_cnt == 4'(K - 1)) begin
               w_state_nxt = PARITY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
            end
         end
         PARITY: begin
            if (r_cnt == 4'(NPAR - 1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Ready is registered so it stays low through reset and drops for exactly
   // the four parity cycles.
   always_comb begin
      w_out_nxt = '0;
      w_rdy_nxt = (w_state_nxt != PARITY);
      if (w_acc) begin
         w_out_nxt.dat   = bus.DATA_IN;
         w_out_nxt.vld   = 1'b1;
         w_out_nxt.first = (r_state == IDLE);
      end else if (r_state == PARITY) begin
         w_out_nxt.dat   = r_lfsr[NPAR-1];
         w_out_nxt.vld   = 1'b1;
         w_out_nxt.last  = (r_cnt == 4'(NPAR - 1));
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_out <= '0;
         r_rdy <= 1'b0;
      end else begin
         r_out <= w_out_nxt;
         r_rdy <= w_rdy_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_lfsr <= '0;
      end else if (r_state == PARITY) begin
         if (r_cnt == 4'(NPAR - 1)) r_lfsr <= '0;
         else                       r_lfsr <= {r_lfsr[NPAR-2:0], {SYM_W{1'b0}}};
      end else if (w_acc) begin
         r_lfsr <= {r_lfsr[NPAR-2:0], {SYM_W{1'b0}}} ^ w_tap;
      end
   end

   assign bus.IN_READY  = r_rdy;
   assign bus.DATA_OUT  = r_out.dat;
   assign bus.OUT_VALID = r_out.vld;
   assign bus.OUT_FIRST = r_out.first;
   assign bus.OUT_LAST  = r_out.last;
endmodule

// File: tb/tb_rs15_11_encoder.sv
// Directed table plus reset, back-to-back and random codewords for the RS(15,11) encoder.
module tb_rs15_11_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rs15_11_encoder_if ifc ();

   rs15_11_encoder dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (ifc.slave)
   );

   typedef struct packed {
      logic [3:0]  d;
      logic        f;
      logic        l;
      logic [31:0] cyc;
   } obs_t;

   typedef struct {
      string       name;
      logic [43:0] msg;
      bit          gap;
      logic [15:0] par;
   } vec_t;

   obs_t obs[$];
   int   cyc = 0;
   int   rdy_low = 0;
   int   rp = 0;
   int   errs = 0;
   int   checks = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n && !ifc.IN_READY) rdy_low = rdy_low + 1;
      if (ifc.OUT_VALID) obs.push_back({ifc.DATA_OUT, ifc.OUT_FIRST, ifc.OUT_LAST, 32'(cyc)});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
      for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
      return p[3:0];
   endfunction

   // Long division of m(x)*x^4 by g(x); remainder is p3..p0.
   function automatic logic [15:0] ref_par(input logic [43:0] m);
      logic [3:0] c[15];
      logic [3:0] g[5];
      logic [3:0] coef;
      g[0] = 4'h1; g[1] = 4'hD; g[2] = 4'hC; g[3] = 4'h8; g[4] = 4'h7;
      for (int i = 0; i < 15; i++) c[i] = (i < 11) ? m[43-4*i -: 4] : 4'h0;
      for (int i = 0; i < 11; i++) begin
         coef = c[i];
         for (int j = 1; j < 5; j++) c[i+j] = c[i+j] ^ gmul(coef, g[j]);
      end
      return {c[11], c[12], c[13], c[14]};
   endfunction

   task automatic send_sym(input logic [3:0] s);
      int n;
      n = 0;
      ifc.DATA_IN  = s;
      ifc.IN_VALID = 1'b1;
      while (!ifc.IN_READY && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("ready_wait", 64'(ifc.IN_READY), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_msg(input logic [43:0] m, input bit gap);
      for (int i = 0; i < 11; i++) begin
         if (gap && i > 0) begin
            ifc.IN_VALID = 1'b0;
            @(posedge clk); #1;
         end
         send_sym(m[43-4*i -: 4]);
      end
   endtask

   task automatic check_cw(input string name, input logic [43:0] m, input logic [15:0] par, input bit gap);
      int         n;
      logic [59:0] dat;
      logic [14:0] fv, lv;
      logic [13:0] sp;
      logic [15:0] syn;
      logic [3:0]  a, s, pw;
      n = 0;
      while (obs.size() < rp + 15 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (obs.size() < rp + 15) begin
         chk({name, "_timeout"}, 64'(obs.size() - rp), 64'd15);
         rp = obs.size();
         return;
      end
      for (int i = 0; i < 15; i++) begin
         dat[59-4*i -: 4] = obs[rp+i].d;
         fv[14-i] = obs[rp+i].f;
         lv[14-i] = obs[rp+i].l;
      end
      for (int i = 0; i < 14; i++)
         sp[i] = ((obs[rp+i+1].cyc - obs[rp+i].cyc) != ((gap && i < 10) ? 32'd2 : 32'd1));
      a = 4'h1;
      for (int j = 0; j < 4; j++) begin
         a = gmul(a, 4'h2);
         s = 4'h0;
         for (int i = 0; i < 15; i++) s = gmul(s, a) ^ dat[59-4*i -: 4];
         syn[15-4*j -: 4] = s;
      end
      pw = 4'h0;
      chk({name, "_data"},    64'(dat), 64'({m, par}));
      chk({name, "_flags"},   64'({fv, lv}), 64'({15'h4000, 15'h0001}));
      chk({name, "_spacing"}, 64'(sp), 64'(0));
      chk({name, "_syndrome"}, 64'(syn), 64'(pw));
      rp += 15;
   endtask

   vec_t tbl[5];
   int   r0, b;
   logic [43:0] rm;
   bit   rg;

   initial begin
      tbl[0] = '{"zero",     44'h0,  1'b0, 16'h0000};
      tbl[1] = '{"one",      44'h1,  1'b0, 16'hDC87};
      tbl[2] = '{"alpha",    44'h2,  1'b0, 16'h9B3E};
      tbl[3] = '{"one_gap",  44'h1,  1'b1, 16'hDC87};
      tbl[4] = '{"three",    44'h3,  1'b0, 16'h47B9};

      ifc.DATA_IN  = 4'h0;
      ifc.IN_VALID = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({ifc.DATA_OUT, ifc.OUT_VALID, ifc.OUT_FIRST, ifc.OUT_LAST, ifc.IN_READY}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", 64'(ifc.IN_READY), 64'd1);

      for (int v = 0; v < 5; v++) begin
         r0 = rdy_low;
         send_msg(tbl[v].msg, tbl[v].gap);
         ifc.IN_VALID = 1'b0;
         check_cw(tbl[v].name, tbl[v].msg, tbl[v].par, tbl[v].gap);
         chk({tbl[v].name, "_ready_low"}, 64'(rdy_low - r0), 64'd4);
         repeat (2) @(posedge clk);
         #1;
      end

      // Back to back: IN_VALID stays high through the parity slots.
      r0 = rdy_low;
      b  = rp;
      send_msg(44'h1, 1'b0);
      send_msg(44'h2, 1'b0);
      ifc.IN_VALID = 1'b0;
      check_cw("b2b_first", 44'h1, 16'hDC87, 1'b0);
      check_cw("b2b_second", 44'h2, 16'h9B3E, 1'b0);
      if (obs.size() >= b + 16)
         chk("b2b_adjacent", 64'(obs[b+15].cyc - obs[b+14].cyc), 64'd1);
      else
         chk("b2b_adjacent", 64'(obs.size()), 64'(b + 16));
      chk("b2b_ready_low", 64'(rdy_low - r0), 64'd8);
      repeat (2) @(posedge clk);
      #1;

      // Abort mid-codeword.
      for (int i = 0; i < 6; i++) send_sym(4'h5 + 4'(i));
      rst_n = 1'b0;
      #2;
      chk("abort_outputs", 64'({ifc.DATA_OUT, ifc.OUT_VALID, ifc.OUT_FIRST, ifc.OUT_LAST, ifc.IN_READY}), 64'd0);
      ifc.IN_VALID = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rp = obs.size();
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_partial", 64'(obs.size()), 64'(rp));
      send_msg(44'h0, 1'b0);
      ifc.IN_VALID = 1'b0;
      check_cw("after_abort", 44'h0, 16'h0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 4; k++) begin
         rm = {12'($urandom), 32'($urandom)};
         rg = 1'($urandom_range(0, 1));
         send_msg(rm, rg);
         ifc.IN_VALID = 1'b0;
         check_cw($sformatf("rand%0d", k), rm, ref_par(rm), rg);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
